// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, load-use bubble insertion, add/sub ALU and
// the EX/MEM pipeline register feeding data memory and write-back.
`timescale 1ns/1ps
module ex_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_alusrc,
  input  logic              id_alufn,
  input  logic              id_memwrite,
  input  logic              id_memread,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              hazard_stall,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu,
  output logic [DATA_W-1:0] mem_store,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_zero,
  output logic              mem_carry,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic              mem_memtoreg,
  output logic              mem_regwrite,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              mem_fwd_ok;
  logic              wb_fwd_ok;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] op_b_alu;
  logic [DATA_W:0]   sum9;
  logic [DATA_W-1:0] alu_res;
  logic              insert_bubble;
  logic              capture;

  // A load sitting in EX/MEM holds an address in mem_alu, so it is never a source.
  assign mem_fwd_ok = mem_valid & mem_regwrite & ~mem_memread & (mem_rd != '0);
  assign wb_fwd_ok  = wb_regwrite & (wb_rd != '0);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    fwd_a = id_a;
    if (mem_fwd_ok && (mem_rd == id_rs))      fwd_a = mem_alu;
    else if (wb_fwd_ok && (wb_rd == id_rs))   fwd_a = wb_data;

    fwd_b = id_b;
    if (mem_fwd_ok && (mem_rd == id_rt))      fwd_b = mem_alu;
    else if (wb_fwd_ok && (wb_rd == id_rt))   fwd_b = wb_data;

    op_b     = id_alusrc ? id_imm : fwd_b;
    op_b_alu = id_alufn ? ~op_b : op_b;
    sum9     = {1'b0, fwd_a} + {1'b0, op_b_alu} + {{DATA_W{1'b0}}, id_alufn};
    alu_res  = sum9[DATA_W-1:0];
  end

  // rt only matters when it feeds the ALU or supplies store data.
  assign hazard_stall = id_valid & mem_valid & mem_memread & mem_regwrite & (mem_rd != '0) &
                        ((mem_rd == id_rs) |
                         ((mem_rd == id_rt) & (~id_alusrc | id_memwrite)));

  assign insert_bubble = flush | (~stall & (hazard_stall | ~id_valid));
  assign capture       = ~flush & ~stall & ~hazard_stall & id_valid;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      mem_valid    <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_regwrite <= 1'b0;
    end else if (insert_bubble) begin
      mem_valid    <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_regwrite <= 1'b0;
    end else if (capture) begin
      mem_valid    <= 1'b1;
      mem_memwrite <= id_memwrite;
      mem_memread  <= id_memread;
      mem_memtoreg <= id_memtoreg;
      mem_regwrite <= id_regwrite;
    end
  end

  // Data fields only move on a real capture; a bubble leaves them stale.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      mem_alu   <= '0;
      mem_store <= '0;
      mem_rd    <= '0;
      mem_zero  <= 1'b0;
      mem_carry <= 1'b0;
    end else if (capture) begin
      mem_alu   <= alu_res;
      mem_store <= fwd_b;
      mem_rd    <= id_rd;
      mem_zero  <= (alu_res == '0);
      mem_carry <= sum9[DATA_W];
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (~flush && ~stall && hazard_stall && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed boundary scenarios plus a randomized
// run against a behavioural model of the forwarding, hazard and ALU rules.
`timescale 1ns/1ps
module tb_ex_stage;

  logic       clk2 = 1'b0;
  logic       rst  = 1'b1;
  logic       id_valid, id_alusrc, id_alufn;
  logic [7:0] id_a, id_b, id_imm;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_memwrite, id_memread, id_memtoreg, id_regwrite;
  logic       stall, flush, wb_regwrite;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;

  logic       hazard_stall, mem_valid, mem_zero, mem_carry;
  logic [7:0] mem_alu, mem_store, bubble_cnt;
  logic [2:0] mem_rd;
  logic       mem_memwrite, mem_memread, mem_memtoreg, mem_regwrite;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the EX/MEM contents used by the random run.
  logic       m_valid, m_mw, m_mr, m_mtr, m_rw, m_z, m_c;
  logic [2:0] m_rd;
  logic [7:0] m_alu, m_store;
  int         m_cnt;

  ex_stage #(.DATA_W(8), .REG_AW(3), .CNT_W(8)) dut (
    .clk2(clk2), .rst(rst), .id_valid(id_valid),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alusrc(id_alusrc), .id_alufn(id_alufn),
    .id_memwrite(id_memwrite), .id_memread(id_memread),
    .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .stall(stall), .flush(flush),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .mem_valid(mem_valid),
    .mem_alu(mem_alu), .mem_store(mem_store), .mem_rd(mem_rd),
    .mem_zero(mem_zero), .mem_carry(mem_carry),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk2 = ~clk2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] obs();
    return {mem_valid, mem_memwrite, mem_memread, mem_memtoreg, mem_regwrite,
            mem_rd, mem_alu, mem_store, mem_zero, mem_carry};
  endfunction

  function automatic logic [25:0] pack(input logic v, mw, mr, mtr, rw,
                                       input logic [2:0] rd,
                                       input logic [7:0] alu, st,
                                       input logic z, c);
    return {v, mw, mr, mtr, rw, rd, alu, st, z, c};
  endfunction

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_a = 0; id_b = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alusrc = 0; id_alufn = 0;
    id_memwrite = 0; id_memread = 0; id_memtoreg = 0; id_regwrite = 0;
    stall = 0; flush = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic drive(input logic [7:0] a, b, imm, input logic [2:0] rs, rt, rd,
                       input logic alusrc, alufn, mw, mr, mtr, rw);
    id_valid = 1; id_a = a; id_b = b; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alusrc = alusrc; id_alufn = alufn;
    id_memwrite = mw; id_memread = mr; id_memtoreg = mtr; id_regwrite = rw;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    #2;
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] want;
    do_reset();
    n_vec++;
    if ({obs(), bubble_cnt, hazard_stall} !== 35'd0) begin
      n_err++; $display("FAIL reset_initial: got %h want 0", {obs(), bubble_cnt, hazard_stall});
    end
    drive(8'h10, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1);        // load r1
    tick();
    drive(8'h00, 8'h01, 0, 1, 0, 4, 0, 0, 0, 0, 0, 1);    // dependent: bubble
    tick();
    drive(8'h10, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1);        // load r1 again
    tick();
    want = pack(1, 0, 1, 1, 1, 1, 8'h10, 8'h00, 0, 0);
    n_vec++;
    if ({obs(), bubble_cnt} !== {want, 8'd1}) begin
      n_err++; $display("FAIL reset_setup: got %h want %h", {obs(), bubble_cnt}, {want, 8'd1});
    end
    stall = 1;
    drive(8'h00, 8'h01, 0, 1, 0, 4, 0, 0, 0, 0, 0, 1);
    #2;
    rst = 1;
    #1;
    n_vec++;
    if ({obs(), bubble_cnt, hazard_stall} !== 35'd0) begin
      n_err++; $display("FAIL reset_mid_stall: got %h want 0", {obs(), bubble_cnt, hazard_stall});
    end
    rst = 0;
    idle();
    #1;
    n_vec++;
    if (mem_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: got %b want 0", mem_valid);
    end
    tick();
    n_vec++;
    if ({mem_valid, bubble_cnt} !== 9'd0) begin
      n_err++; $display("FAIL reset_after_edge: got %h want 0", {mem_valid, bubble_cnt});
    end
  endtask

  task automatic test_alu_boundaries();
    logic [25:0] want;
    do_reset();
    drive(8'hFF, 8'h01, 0, 1, 2, 4, 0, 0, 0, 0, 0, 1);
    tick();
    want = pack(1, 0, 0, 0, 1, 4, 8'h00, 8'h01, 1, 1);
    n_vec++;
    if (obs() !== want) begin n_err++; $display("FAIL alu_add_wrap: got %h want %h", obs(), want); end
    drive(8'h05, 8'h07, 0, 5, 6, 4, 0, 1, 0, 0, 0, 1);
    tick();
    want = pack(1, 0, 0, 0, 1, 4, 8'hFE, 8'h07, 0, 0);
    n_vec++;
    if (obs() !== want) begin n_err++; $display("FAIL alu_sub_borrow: got %h want %h", obs(), want); end
    drive(8'h10, 8'h33, 8'h80, 1, 2, 5, 1, 0, 1, 0, 0, 0);
    tick();
    want = pack(1, 1, 0, 0, 0, 5, 8'h90, 8'h33, 0, 0);
    n_vec++;
    if (obs() !== want) begin n_err++; $display("FAIL alu_imm: got %h want %h", obs(), want); end
    drive(8'h80, 8'h01, 8'h80, 1, 2, 6, 1, 1, 0, 0, 0, 1);
    tick();
    want = pack(1, 0, 0, 0, 1, 6, 8'h00, 8'h01, 1, 1);
    n_vec++;
    if (obs() !== want) begin n_err++; $display("FAIL alu_sub_imm_equal: got %h want %h", obs(), want); end
  endtask

  task automatic test_forward_priority();
    logic [25:0] want;
    do_reset();
    drive(8'h11, 8'h00, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1);
    tick();
    wb_regwrite = 1; wb_rd = 3; wb_data = 8'h22;
    drive(8'h99, 8'h55, 8'h01, 3, 3, 5, 1, 0, 0, 0, 0, 1);
    tick();
    want = pack(1, 0, 0, 0, 1, 5, 8'h12, 8'h11, 0, 0);
    n_vec++;
    if (obs() !== want) begin n_err++; $display("FAIL fwd_mem_over_wb: got %h want %h", obs(), want); end
    drive(8'h99, 8'h07, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    want = pack(1, 0, 0, 0, 1, 0, 8'h29, 8'h07, 0, 0);
    n_vec++;
    if (obs() !== want) begin n_err++; $display("FAIL fwd_wb_only: got %h want %h", obs(), want); end
    wb_rd = 0; wb_data = 8'h77;
    drive(8'h40, 8'h02, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tick();
    want = pack(1, 0, 0, 0, 1, 1, 8'h42, 8'h02, 0, 0);
    n_vec++;
    if (obs() !== want) begin n_err++; $display("FAIL fwd_r0_never: got %h want %h", obs(), want); end
    wb_regwrite = 0;
    drive(8'h30, 8'h00, 8'h00, 0, 0, 4, 1, 0, 0, 1, 1, 1);  // load r4
    tick();
    wb_regwrite = 1; wb_rd = 4; wb_data = 8'h66;
    drive(8'h01, 8'hEE, 8'h01, 0, 4, 2, 1, 0, 0, 0, 0, 1);
    #1;
    n_vec++;
    if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL no_haz_rt_imm: got %b want 0", hazard_stall); end
    tick();
    want = pack(1, 0, 0, 0, 1, 2, 8'h02, 8'h66, 0, 0);
    n_vec++;
    if (obs() !== want) begin n_err++; $display("FAIL load_not_fwd: got %h want %h", obs(), want); end
  endtask

  task automatic test_load_use();
    logic [25:0] want;
    do_reset();
    drive(8'h10, 8'h00, 8'h04, 0, 0, 2, 1, 0, 0, 1, 1, 1);
    tick();
    drive(8'h00, 8'h03, 0, 2, 1, 6, 0, 0, 0, 0, 0, 1);
    #1;
    n_vec++;
    if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL loaduse_haz: got %b want 1", hazard_stall); end
    tick();
    n_vec++;
    if ({obs() >> 21, bubble_cnt} !== {5'd0, 8'd1}) begin
      n_err++; $display("FAIL loaduse_bubble: got %h want %h", {obs() >> 21, bubble_cnt}, {5'd0, 8'd1});
    end
    wb_regwrite = 1; wb_rd = 2; wb_data = 8'h5A;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL loaduse_haz_clear: got %b want 0", hazard_stall); end
    tick();
    want = pack(1, 0, 0, 0, 1, 6, 8'h5D, 8'h03, 0, 0);
    n_vec++;
    if ({obs(), bubble_cnt} !== {want, 8'd1}) begin
      n_err++; $display("FAIL loaduse_wb_fwd: got %h want %h", {obs(), bubble_cnt}, {want, 8'd1});
    end
    wb_regwrite = 0;
    drive(8'h10, 8'h00, 8'h04, 0, 0, 2, 1, 0, 0, 1, 1, 1);
    tick();
    drive(8'h00, 8'h03, 8'h01, 0, 2, 6, 1, 0, 1, 0, 0, 0);   // store with rt=2
    #1;
    n_vec++;
    if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL haz_rt_store: got %b want 1", hazard_stall); end
    id_memwrite = 0; id_alusrc = 0;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL haz_rt_reg: got %b want 1", hazard_stall); end
    id_alusrc = 1;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL haz_rt_imm: got %b want 0", hazard_stall); end
    id_valid = 0; id_rs = 2;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL haz_invalid: got %b want 0", hazard_stall); end
    idle();
    tick();
  endtask

  task automatic test_stall_flush();
    logic [25:0] want;
    do_reset();
    drive(8'h21, 8'h02, 0, 4, 5, 6, 0, 0, 0, 0, 0, 1);
    tick();
    want = pack(1, 0, 0, 0, 1, 6, 8'h23, 8'h02, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(8'hAA + 8'(i), 8'h01, 8'h0F, 1, 2, 7, i[0], 1, 1, 0, 1, 0);
      tick();
      n_vec++;
      if (obs() !== want) begin n_err++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs(), want); end
    end
    stall = 0;
    drive(8'h40, 8'h00, 8'h01, 0, 0, 3, 1, 0, 0, 1, 1, 1);
    tick();
    stall = 1;
    drive(8'h00, 8'h01, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1);
    tick();
    want = pack(1, 0, 1, 1, 1, 3, 8'h41, 8'h00, 0, 0);
    n_vec++;
    if ({obs(), bubble_cnt} !== {want, 8'd0}) begin
      n_err++; $display("FAIL stall_over_haz: got %h want %h", {obs(), bubble_cnt}, {want, 8'd0});
    end
    flush = 1;
    tick();
    n_vec++;
    if ({obs() >> 21, bubble_cnt} !== 13'd0) begin
      n_err++; $display("FAIL stall_flush_bubble: got %h want 0", {obs() >> 21, bubble_cnt});
    end
    idle();
    tick();
  endtask

  task automatic test_counter_saturation();
    do_reset();
    drive(8'h01, 8'h00, 8'h00, 1, 0, 1, 1, 0, 0, 1, 1, 1);  // load r1 reading r1
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (k == 508 || k == 510 || k == 600) begin
        n_vec++;
        if (int'(bubble_cnt) !== ((k / 2 > 255) ? 255 : k / 2)) begin
          n_err++; $display("FAIL cnt_sat_%0d: got %0d want %0d", k, bubble_cnt, (k / 2 > 255) ? 255 : k / 2);
        end
      end
    end
    idle();
  endtask

  function automatic logic [7:0] model_fwd(input logic [2:0] idx, input logic [7:0] val);
    if (m_valid && m_rw && !m_mr && m_rd != 0 && m_rd == idx) return m_alu;
    if (wb_regwrite && wb_rd != 0 && wb_rd == idx) return wb_data;
    return val;
  endfunction

  task automatic test_random();
    logic [7:0] fa, fb, ob, res;
    logic       c, haz;
    int         s;
    do_reset();
    m_valid = 0; m_mw = 0; m_mr = 0; m_mtr = 0; m_rw = 0; m_z = 0; m_c = 0;
    m_rd = 0; m_alu = 0; m_store = 0; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 99) < 85);
      id_a = 8'($urandom); id_b = 8'($urandom); id_imm = 8'($urandom);
      id_rs = 3'($urandom_range(0, 3)); id_rt = 3'($urandom_range(0, 3));
      id_rd = 3'($urandom_range(0, 3));
      id_alusrc = 1'($urandom); id_alufn = 1'($urandom);
      id_memread = ($urandom_range(0, 99) < 35);
      id_memtoreg = id_memread;
      id_memwrite = !id_memread && ($urandom_range(0, 99) < 20);
      id_regwrite = ($urandom_range(0, 99) < 75);
      stall = ($urandom_range(0, 99) < 10);
      flush = ($urandom_range(0, 99) < 5);
      wb_regwrite = 1'($urandom); wb_rd = 3'($urandom_range(0, 3)); wb_data = 8'($urandom);
      #1;
      fa = model_fwd(id_rs, id_a);
      fb = model_fwd(id_rt, id_b);
      ob = id_alusrc ? id_imm : fb;
      if (!id_alufn) begin
        s = int'(fa) + int'(ob); c = (s > 255); res = 8'(s % 256);
      end else begin
        s = int'(fa) - int'(ob); c = (s >= 0); res = 8'((s + 256) % 256);
      end
      haz = id_valid && m_valid && m_mr && m_rw && m_rd != 0 &&
            (m_rd == id_rs || (m_rd == id_rt && (!id_alusrc || id_memwrite)));
      n_vec++;
      if (hazard_stall !== haz) begin
        n_err++; $display("FAIL rand_haz_%0d: got %b want %b", i, hazard_stall, haz);
      end
      tick();
      if (flush) begin
        m_valid = 0; {m_mw, m_mr, m_mtr, m_rw} = 4'b0;
      end else if (stall) begin
        m_valid = m_valid;
      end else if (haz || !id_valid) begin
        m_valid = 0; {m_mw, m_mr, m_mtr, m_rw} = 4'b0;
        if (haz && m_cnt < 255) m_cnt++;
      end else begin
        m_valid = 1; m_mw = id_memwrite; m_mr = id_memread; m_mtr = id_memtoreg;
        m_rw = id_regwrite; m_rd = id_rd; m_alu = res; m_store = fb;
        m_z = (res == 0); m_c = c;
      end
      n_vec++;
      if ({obs() >> 21, bubble_cnt} !== {m_valid, m_mw, m_mr, m_mtr, m_rw, 8'(m_cnt)}) begin
        n_err++; $display("FAIL rand_ctrl_%0d: got %h want %h", i, {obs() >> 21, bubble_cnt},
                          {m_valid, m_mw, m_mr, m_mtr, m_rw, 8'(m_cnt)});
      end
      if (m_valid) begin
        n_vec++;
        if (obs() !== pack(m_valid, m_mw, m_mr, m_mtr, m_rw, m_rd, m_alu, m_store, m_z, m_c)) begin
          n_err++; $display("FAIL rand_data_%0d: got %h want %h", i, obs(),
                            pack(m_valid, m_mw, m_mr, m_mtr, m_rw, m_rd, m_alu, m_store, m_z, m_c));
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    #3;
    test_reset();
    test_alu_boundaries();
    test_forward_priority();
    test_load_use();
    test_stall_flush();
    test_counter_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
